mips32_fetch_queue: RTL and testbench
=====================================

Name: mips32_fetch_queue

Overview:
- Decoupled instruction-fetch front end for the MIPS32 pipeline. It sits directly upstream of the IF/ID register and the decode stage.
- Issues word-addressed reads to instruction memory over a req/gnt request channel and an in-order rvalid response channel.
- Buffers returned instructions, each with its next-PC, in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts branch redirects from EX; a redirect flushes all buffered and in-flight instructions.

Parameters:
- DEPTH, 4: instruction FIFO entries; also the cap on (buffered + outstanding) fetches. Power of two, >= 2.
- ADDR_W, 10: instruction memory word-address width.
- RESET_PC, 32'h0000_0000: PC loaded on reset.

Ports:
- clk1  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- redirect_valid  in  1  taken branch from EX, one-cycle pulse.
- redirect_pc  in  32  branch target (word address).
- halt  in  1  stop issuing new fetches (level).
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch word address, equal to pc[ADDR_W-1:0].
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; responses return in request order, latency >= 1.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts this cycle.
- if_ir  out  32  instruction at FIFO head.
- if_npc  out  32  address of that instruction + 1.
- fetch_pc  out  32  next address to be requested (debug).

Behaviour:
- Reset (rst=1 at posedge):
  - pc = resp_pc = RESET_PC; FIFO empty; outstanding = 0; drop_cnt = 0.
  - Outputs: if_valid=0, imem_req=0, if_ir=0, if_npc=0, fetch_pc=RESET_PC.
  - Reset overrides every other input in the same cycle, including mid-transfer.
- Request issue, combinational from registered state: imem_req = !rst && !halt && !redirect_valid && (count + outstanding < DEPTH).
- Request handshake: a request is accepted when imem_req && imem_gnt. On acceptance pc <= pc+1 and outstanding++. imem_addr must be held stable while imem_req=1 and imem_gnt=0.
- Response with drop_cnt > 0: the word is discarded; drop_cnt-- and outstanding--.
- Response with drop_cnt = 0:
  - Push {ir=imem_rdata, npc=resp_pc+1}; then resp_pc++ and outstanding--.
  - The credit rule guarantees the push never sees a full FIFO.
- Decode handshake: pop when if_valid && if_ready. if_ir/if_npc come from the FIFO head, registered storage with zero-latency read. A push and a pop in the same cycle leave count unchanged.
- Redirect (redirect_valid=1), highest priority after rst:
  - if_valid forced to 0 that cycle; no pop, no push, no new request.
  - FIFO flushed; pc <= redirect_pc; resp_pc <= redirect_pc.
  - drop_cnt <= outstanding - imem_rvalid. A response arriving in the redirect cycle is itself discarded. outstanding is updated by the normal response rule.
  - First request to redirect_pc is issued the following cycle at the earliest.
- Halt:
  - Only request issue is blocked. Outstanding responses are still accepted and buffered, and the FIFO still drains to decode.
  - A redirect while halted updates pc and flushes as normal.
- Arithmetic:
  - pc, resp_pc and npc are 32-bit and wrap from 32'hFFFF_FFFF to 0.
  - imem_addr truncates pc to its low ADDR_W bits.
  - count and outstanding are clog2(DEPTH)+1 bits wide and never exceed DEPTH.
- Protocol violation: imem_rvalid with outstanding = 0 is ignored (no state change) and must be flagged by a bench assertion.
- Latency: with 1-cycle memory, no stalls, and imem_gnt held at 1, the first if_valid comes 2 cycles after reset release. After that, one instruction per cycle is sustained.

Decomposition:
- Shared package mips32_pkg holds:
  - the opcode constants and the instruction-type encodings already used by the pipeline;
  - a fetch-entry struct {ir[31:0], npc[31:0]};
  - INSTR_W=32.
- One sub-module: mips32_sync_fifo, parameterised on width and depth, with push/pop/flush and full/empty/count outputs.
- The top level holds the pc, resp_pc, outstanding and drop_cnt counters and the handshake logic.

Test Plan:
1. Memory returns Mem[i]=32'h1000_0000+i at latency 1, if_ready=1 → if_ir sequence 0x10000000..0x10000003 with if_npc=1..4; no bubbles after the first.
2. if_ready=0 for 10 cycles → imem_req falls once count+outstanding reaches 4 and exactly 4 requests are issued. Releasing if_ready drains 4 in order, then streaming resumes at pc=4.
3. Latency 3 with 2 requests in flight, then redirect_pc=32'h20 → the next 2 rvalids are dropped; first delivered is if_ir=Mem[0x20], if_npc=32'h21.
4. Redirect in the same cycle as an rvalid with outstanding=1 → drop_cnt=0 afterwards, the response is not pushed, and the next delivered instruction is from the target.
5. Assert halt with 2 in flight and 1 buffered → no further imem_req; 3 instructions are still delivered; if_valid stays 0 afterwards.
6. rst=1 mid-stream with FIFO at 3 entries → next cycle if_valid=0 and fetch_pc=RESET_PC; the late responses still pending from before reset are treated as violations and ignored.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline definitions: opcodes, instruction classes and the fetch-queue entry.
package mips32_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        InstrR,
        InstrI,
        InstrJ
    } instr_type_e;

    typedef struct packed {
        logic [INSTR_W-1:0] ir;
        logic [INSTR_W-1:0] npc;
    } fetch_entry_t;

endpackage

// File: rtl/mips32_sync_fifo.sv
// Synchronous FIFO with registered storage and zero-latency head read; flush empties it in one cycle.
module mips32_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk1,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk1) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/mips32_fetch_queue.sv
// Decoupled instruction fetch: credit-limited imem requests, in-order responses buffered for decode,
// and redirect flush that discards every in-flight response.
module mips32_fetch_queue
    import mips32_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              halt,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_ir,
    output logic [31:0]       if_npc,
    output logic [31:0]       fetch_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      pc_q, resp_pc_q;
    logic [CNT_W-1:0] outst_q, drop_q, count;
    logic [CNT_W:0]   in_use;
    logic             fifo_full, fifo_empty;
    logic             accept, resp, push, pop;
    fetch_entry_t     push_entry, head;

    // Buffered plus outstanding fetches share one credit pool so a response always has a slot.
    assign in_use   = {1'b0, count} + {1'b0, outst_q};
    assign imem_req = !rst && !halt && !redirect_valid && (in_use < (CNT_W + 1)'(DEPTH));
    assign accept   = imem_req && imem_gnt;
    // A response with nothing outstanding is a protocol violation and is ignored.
    assign resp     = imem_rvalid && (outst_q != '0);
    assign push     = resp && !redirect_valid && (drop_q == '0) && !fifo_full;
    assign if_valid = !fifo_empty && !redirect_valid;
    assign pop      = if_valid && if_ready;

    assign push_entry = '{ir: imem_rdata, npc: resp_pc_q + 32'd1};
    assign if_ir      = fifo_empty ? '0 : head.ir;
    assign if_npc     = fifo_empty ? '0 : head.npc;
    assign imem_addr  = pc_q[ADDR_W-1:0];
    assign fetch_pc   = pc_q;

    mips32_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk1  (clk1),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    always_ff @(posedge clk1) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= '0;
            drop_q    <= '0;
        end else begin
            outst_q <= outst_q + CNT_W'(accept) - CNT_W'(resp);
            if (redirect_valid) begin
                pc_q      <= redirect_pc;
                resp_pc_q <= redirect_pc;
                drop_q    <= outst_q - CNT_W'(resp);
            end else begin
                if (accept) begin
                    pc_q <= pc_q + 32'd1;
                end
                if (push) begin
                    resp_pc_q <= resp_pc_q + 32'd1;
                end
                if (resp && (drop_q != '0)) begin
                    drop_q <= drop_q - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Scoreboard bench: accepted fetches queue their expected {ir, npc}; a monitor checks decode handshakes.
module tb_mips32_fetch_queue;
    import mips32_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned ADDR_W   = 10;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic              clk1 = 1'b0;
    logic              rst, redirect_valid, halt, imem_gnt, imem_rvalid, if_ready;
    logic [31:0]       redirect_pc, imem_rdata;
    logic              imem_req, if_valid;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       if_ir, if_npc, fetch_pc;

    mips32_fetch_queue #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk1           (clk1),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_ir          (if_ir),
        .if_npc         (if_npc),
        .fetch_pc       (fetch_pc)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    int tests = 0;
    int fails = 0;

    fetch_entry_t q[$];      // expected deliveries, current epoch, in program order
    pend_t        pend[$];   // memory-side requests awaiting a response
    logic [31:0]  model_pc = RESET_PC;
    int           epoch = 0;
    int           cyc = 0;
    bit           exp_viol = 0;

    // Knobs written by the sequencer just after posedge, read by the driver at negedge.
    bit          force_rst = 1, force_halt = 0, redir_once = 0, inject_viol = 0, halt_r = 0;
    logic [31:0] redir_target = 32'h0;
    int          p_gnt = 0, p_ready = 0, p_redir = 0, p_halt = 0, p_rst = 0;
    int          lat_min = 1, lat_max = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [ADDR_W-1:0] w;
        w = a[ADDR_W-1:0];
        return 32'h1000_0000 + 32'(w);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver, memory model and request-side reference.
    always @(negedge clk1) begin
        int  ncur, used;
        bit  exp_req;
        cyc++;
        rst = force_rst || (p_rst > 0 && $urandom_range(999) < p_rst);
        redirect_valid = 1'b0;
        if (!rst && (redir_once || $urandom_range(99) < p_redir)) begin
            redirect_valid = 1'b1;
            case ($urandom_range(2))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = 32'hFFFF_FFFE;
                default: redirect_pc = 32'h20 + 32'($urandom_range(15));
            endcase
            if (redir_once) redirect_pc = redir_target;
            redir_once = 0;
        end
        if ($urandom_range(99) < p_halt) halt_r = !halt_r;
        halt        = force_halt || (p_halt > 0 && halt_r);
        imem_gnt    = $urandom_range(99) < p_gnt;
        if_ready    = $urandom_range(99) < p_ready;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
        end else if (!rst && inject_viol && pend.size() == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
            inject_viol = 0;
            exp_viol    = 1;
        end
        #1;
        if (imem_rvalid && pend.size() == 0) begin
            assert (exp_viol) else $error("imem_rvalid with no outstanding fetch");
        end
        exp_viol = 0;
        ncur = 0;
        foreach (pend[i]) if (pend[i].epoch == epoch) ncur++;
        used    = pend.size() + (q.size() - ncur);
        exp_req = !rst && !halt && !redirect_valid && (used < DEPTH);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        check("fetch_pc", fetch_pc, model_pc);
        if (exp_req && imem_req) check("imem_addr", 32'(imem_addr), 32'(model_pc[ADDR_W-1:0]));
        if (rst) begin
            q.delete();
            pend.delete();
            model_pc = RESET_PC;
            epoch++;
        end else begin
            if (imem_rvalid && pend.size() > 0) void'(pend.pop_front());
            if (redirect_valid) begin
                q.delete();
                epoch++;
                model_pc = redirect_pc;
            end else if (exp_req && imem_gnt) begin
                pend.push_back('{addr: model_pc, epoch: epoch,
                                 due: cyc + int'($urandom_range(lat_max, lat_min))});
                q.push_back('{ir: mem_word(model_pc), npc: model_pc + 32'd1});
                model_pc = model_pc + 32'd1;
            end
        end
    end

    // Monitor: compares the FIFO head with the scoreboard and retires it on a decode handshake.
    always @(negedge clk1) begin
        fetch_entry_t e;
        #2;
        if (!rst) begin
            if (redirect_valid) begin
                check("if_valid_in_redirect", 32'(if_valid), 32'd0);
            end else if (if_valid) begin
                if (q.size() == 0) begin
                    fails++;
                    tests++;
                    $display("FAIL unexpected_if_valid: got 1 expected 0 (t=%0t)", $time);
                end else if (if_ready) begin
                    e = q.pop_front();
                    check("if_ir", if_ir, e.ir);
                    check("if_npc", if_npc, e.npc);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; if_ready = 1'b0;

        repeat (3) @(posedge clk1);
        @(negedge clk1); #3;
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_ir", if_ir, 32'd0);
        check("rst_if_npc", if_npc, 32'd0);
        check("rst_fetch_pc", fetch_pc, RESET_PC);

        // Streaming with 1-cycle memory: two-cycle startup, then no bubbles.
        @(posedge clk1); #1;
        force_rst = 0; p_gnt = 100; p_ready = 100; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk1); #3;
            check("startup_if_valid", 32'(if_valid), (i >= 2) ? 32'd1 : 32'd0);
        end

        // Decode stall: credits run out, then drain and resume.
        @(posedge clk1); #1; p_ready = 0;
        repeat (10) @(posedge clk1);
        @(negedge clk1); #3;
        check("stall_imem_req", 32'(imem_req), 32'd0);
        check("stall_if_valid", 32'(if_valid), 32'd1);
        @(posedge clk1); #1; p_ready = 100;
        repeat (12) @(posedge clk1);

        // Slow memory then redirect to 0x20 with fetches in flight.
        #1; lat_min = 3; lat_max = 3;
        repeat (6) @(posedge clk1);
        #1; redir_target = 32'h20; redir_once = 1;
        repeat (12) @(posedge clk1);

        // Halt: in-flight work still drains, nothing new is issued.
        #1; force_halt = 1;
        repeat (10) @(posedge clk1);
        @(negedge clk1); #3;
        check("halt_imem_req", 32'(imem_req), 32'd0);
        check("halt_if_valid", 32'(if_valid), 32'd0);

        // Reset while halted, then a stray response with nothing outstanding.
        @(posedge clk1); #1; force_rst = 1;
        @(posedge clk1); #1; force_rst = 0; inject_viol = 1;
        repeat (4) @(posedge clk1);
        @(negedge clk1); #3;
        check("viol_if_valid", 32'(if_valid), 32'd0);
        check("viol_fetch_pc", fetch_pc, RESET_PC);

        // Randomized traffic: grants, ready, latency, redirects, halts, occasional reset.
        @(posedge clk1); #1;
        force_halt = 0; p_gnt = 70; p_ready = 70; p_redir = 3; p_halt = 4; p_rst = 5;
        lat_min = 1; lat_max = 3;
        repeat (3000) @(posedge clk1);

        // Drain everything still expected.
        #1; p_redir = 0; p_halt = 0; p_rst = 0; force_halt = 1; p_ready = 100;
        repeat (30) @(posedge clk1);
        @(negedge clk1); #3;
        check("drain_remaining", 32'(q.size()), 32'd0);
        check("drain_if_valid", 32'(if_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
